window_spill_fill: RTL and testbench

Register-window management and spill/fill engine for the SPARC register file. It tracks CWP, CanSave and CanRestore, drives the one-hot window enable of the register window, and executes SAVE/RESTORE in one cycle when the window state allows. On window overflow it reads the oldest resident window out of the register file and writes it to memory (spill). On underflow it reads a spilled window back from memory and writes it into the register file (fill). It is the reading/draining end of the register-window write port, and sits between the decode stage and the register window/data memory.

---
 rtl/regwin_pkg.sv | 23 ++
 rtl/window_spill_fill_if.sv | 31 +++
 rtl/window_onehot.sv | 14 +
 rtl/window_spill_fill.sv | 183 ++++++++++++++++++
 tb/tb_window_spill_fill.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/regwin_pkg.sv
// Shared definitions for the register-window spill/fill engine and the register file.
package regwin_pkg;
    localparam int NWINDOWS      = 8;
    localparam int REG_BASE      = 16;
    localparam int WORDS_PER_WIN = 16;
    localparam int FRAME_BYTES   = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPILL_RD,
        ST_SPILL_WR,
        ST_FILL_RD,
        ST_FILL_WR
    } state_e;

    // Window index arithmetic, (w + k) mod n; k may be negative.
    function automatic logic [2:0] win_wrap(input logic [2:0] w, input int k, input int n);
        int s;
        s = (int'(w) + k) % n;
        if (s < 0) s = s + n;
        return 3'(s);
    endfunction
endpackage

// File: rtl/window_spill_fill_if.sv
// Decode-side, register-window and data-memory signals of the spill/fill engine.
interface window_spill_fill_if #(parameter int NWINDOWS = 8);
    logic                Save;
    logic                Restore;
    logic                Busy;
    logic                Error;
    logic [2:0]          CWP;
    logic [NWINDOWS-1:0] RE;
    logic [4:0]          RfAddr;
    logic [31:0]         RfRdata;
    logic [31:0]         RfWdata;
    logic                RfWE;
    logic                MemReq;
    logic                MemWr;
    logic [31:0]         MemAddr;
    logic [31:0]         MemWdata;
    logic [31:0]         MemRdata;
    logic                MemAck;

    modport master (
        output Save, Restore, RfRdata, MemRdata, MemAck,
        input  Busy, Error, CWP, RE, RfAddr, RfWdata, RfWE,
               MemReq, MemWr, MemAddr, MemWdata
    );

    modport slave (
        input  Save, Restore, RfRdata, MemRdata, MemAck,
        output Busy, Error, CWP, RE, RfAddr, RfWdata, RfWE,
               MemReq, MemWr, MemAddr, MemWdata
    );
endinterface

// File: rtl/window_onehot.sv
// Window index to one-hot enable decoder, shared with the register file.
module window_onehot #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [W-1:0] idx,
    output logic [N-1:0] onehot
);
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dec
            assign onehot[gi] = (idx == W'(gi));
        end
    endgenerate
endmodule

// File: rtl/window_spill_fill.sv
// SPARC register-window bookkeeping with a word-serial spill/fill engine
// moving registers 16..31 between the register window and data memory.
module window_spill_fill
    import regwin_pkg::*;
#(
    parameter int          NWINDOWS   = regwin_pkg::NWINDOWS,
    parameter logic [31:0] SPILL_BASE = 32'h0000_F000,
    parameter int          MAX_DEPTH  = 255
) (
    input  logic Clk,
    input  logic Rst_n,
    window_spill_fill_if.slave bus
);
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    state_e              state_q, state_d;
    logic [2:0]          cwp_q, cwp_d;
    logic [2:0]          can_save_q, can_save_d;
    logic [2:0]          can_restore_q, can_restore_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic [31:0]         spill_ptr_q, spill_ptr_d;
    logic [3:0]          idx_q, idx_d;
    logic [2:0]          win_q, win_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;
    logic                rf_we_q, rf_we_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_wr_q, mem_wr_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [31:0]         rf_wdata_q, rf_wdata_d;
    logic [2:0]          re_idx;
    logic [NWINDOWS-1:0] re_onehot;

    always_comb begin
        state_d       = state_q;
        cwp_d         = cwp_q;
        can_save_d    = can_save_q;
        can_restore_d = can_restore_q;
        depth_d       = depth_q;
        spill_ptr_d   = spill_ptr_q;
        idx_d         = idx_q;
        win_d         = win_q;
        error_d       = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rf_wdata_d    = rf_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.Save && bus.Restore) begin
                    error_d = 1'b1;
                end else if (bus.Save) begin
                    if (can_save_q != 3'd0) begin
                        cwp_d         = win_wrap(cwp_q, -1, NWINDOWS);
                        can_save_d    = can_save_q - 3'd1;
                        can_restore_d = can_restore_q + 3'd1;
                    end else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
                        error_d = 1'b1;
                    end else begin
                        // Oldest resident window sits two beyond the current one.
                        win_d   = win_wrap(cwp_q, 2, NWINDOWS);
                        idx_d   = 4'd0;
                        state_d = ST_SPILL_RD;
                    end
                end else if (bus.Restore) begin
                    if (can_restore_q != 3'd0) begin
                        cwp_d         = win_wrap(cwp_q, 1, NWINDOWS);
                        can_restore_d = can_restore_q - 3'd1;
                        can_save_d    = can_save_q + 3'd1;
                    end else if (depth_q != '0) begin
                        spill_ptr_d = spill_ptr_q - 32'(FRAME_BYTES);
                        win_d       = win_wrap(cwp_q, 1, NWINDOWS);
                        idx_d       = 4'd0;
                        state_d     = ST_FILL_RD;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_SPILL_RD: begin
                mem_wdata_d = bus.RfRdata;
                state_d     = ST_SPILL_WR;
            end
            ST_SPILL_WR: begin
                if (bus.MemAck) begin
                    if (idx_q == 4'(WORDS_PER_WIN - 1)) begin
                        spill_ptr_d = spill_ptr_q + 32'(FRAME_BYTES);
                        depth_d     = depth_q + DEPTH_W'(1);
                        cwp_d       = win_wrap(cwp_q, -1, NWINDOWS);
                        state_d     = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_SPILL_RD;
                    end
                end
            end
            ST_FILL_RD: begin
                if (bus.MemAck) begin
                    rf_wdata_d = bus.MemRdata;
                    state_d    = ST_FILL_WR;
                end
            end
            ST_FILL_WR: begin
                if (idx_q == 4'(WORDS_PER_WIN - 1)) begin
                    depth_d = depth_q - DEPTH_W'(1);
                    cwp_d   = win_wrap(cwp_q, 1, NWINDOWS);
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_FILL_RD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered strobes are derived from the state being entered.
        busy_d    = (state_d != ST_IDLE);
        mem_req_d = (state_d == ST_SPILL_WR) || (state_d == ST_FILL_RD);
        mem_wr_d  = (state_d == ST_SPILL_WR);
        rf_we_d   = (state_d == ST_FILL_WR);
        if (mem_req_d) begin
            mem_addr_d = spill_ptr_d + {26'd0, idx_d, 2'b00};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= ST_IDLE;
            cwp_q         <= 3'd0;
            can_save_q    <= 3'(NWINDOWS - 2);
            can_restore_q <= 3'd0;
            depth_q       <= '0;
            spill_ptr_q   <= SPILL_BASE;
            idx_q         <= 4'd0;
            win_q         <= 3'd0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
            rf_we_q       <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_wdata_q   <= 32'd0;
            rf_wdata_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            cwp_q         <= cwp_d;
            can_save_q    <= can_save_d;
            can_restore_q <= can_restore_d;
            depth_q       <= depth_d;
            spill_ptr_q   <= spill_ptr_d;
            idx_q         <= idx_d;
            win_q         <= win_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
            rf_we_q       <= rf_we_d;
            mem_req_q     <= mem_req_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rf_wdata_q    <= rf_wdata_d;
        end
    end

    assign re_idx = (state_q == ST_IDLE) ? cwp_q : win_q;

    window_onehot #(.N(NWINDOWS), .W(3)) u_re_dec (
        .idx    (re_idx),
        .onehot (re_onehot)
    );

    assign bus.RE       = re_onehot;
    assign bus.RfAddr   = (state_q == ST_IDLE) ? 5'd0 : 5'(REG_BASE) + {1'b0, idx_q};
    assign bus.Busy     = busy_q;
    assign bus.Error    = error_q;
    assign bus.CWP      = cwp_q;
    assign bus.RfWE     = rf_we_q;
    assign bus.RfWdata  = rf_wdata_q;
    assign bus.MemReq   = mem_req_q;
    assign bus.MemWr    = mem_wr_q;
    assign bus.MemAddr  = mem_addr_q;
    assign bus.MemWdata = mem_wdata_q;
endmodule

// File: tb/tb_window_spill_fill.sv
// Directed bench: window bookkeeping table, spill, fill, MemAck stall and mid-spill reset.
module tb_window_spill_fill;
    import regwin_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    window_spill_fill_if #(.NWINDOWS(8)) bus ();

    window_spill_fill #(
        .NWINDOWS   (8),
        .SPILL_BASE (32'h0000_F000),
        .MAX_DEPTH  (255)
    ) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register window model: window 4 holds 0x1110+i in registers 16+i.
    assign bus.RfRdata = (bus.RE == 8'b0001_0000)
                       ? 32'h0000_1110 + {27'd0, bus.RfAddr} - 32'd16
                       : 32'hBAD0_0000;

    typedef struct {
        logic       s;
        logic       r;
        logic [2:0] cwp;
        logic       err;
    } vec_t;

    vec_t        vt[14];
    logic [31:0] mem_model[64];
    logic [31:0] wr_addr[64], wr_data[64];
    logic [31:0] we_data[64];
    logic [7:0]  we_re[64];
    logic [4:0]  we_addr[64];
    int          n_wr, n_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic do_req(input logic s, input logic r);
        @(negedge clk);
        bus.Save = s;
        bus.Restore = r;
        @(negedge clk);
        bus.Save = 1'b0;
        bus.Restore = 1'b0;
    endtask

    // Services the memory side while Busy, sampling on falling edges.
    task automatic run_op(input int stall_word, input int stall_n, input int max_cycles,
                          output int cycles);
        int          stall_left;
        logic [31:0] off;
        stall_left = stall_n;
        cycles = 0;
        n_wr = 0;
        n_we = 0;
        while (bus.Busy && cycles < max_cycles) begin
            bus.MemAck = 1'b1;
            off = bus.MemAddr - 32'h0000_F000;
            if (bus.MemReq && bus.MemWr) begin
                if (n_wr == stall_word && stall_left > 0) begin
                    bus.MemAck = 1'b0;
                    stall_left--;
                    chk("stall_addr", bus.MemAddr, 32'h0000_F000 + 32'(4 * stall_word));
                    chk("stall_wdata", bus.MemWdata, 32'h0000_1110 + 32'(stall_word));
                end else if (n_wr < 64) begin
                    wr_addr[n_wr] = bus.MemAddr;
                    wr_data[n_wr] = bus.MemWdata;
                    mem_model[off[7:2]] = bus.MemWdata;
                    n_wr++;
                end
            end
            if (bus.MemReq && !bus.MemWr) bus.MemRdata = mem_model[off[7:2]];
            if (bus.RfWE && n_we < 64) begin
                we_re[n_we]   = bus.RE;
                we_addr[n_we] = bus.RfAddr;
                we_data[n_we] = bus.RfWdata;
                n_we++;
            end
            cycles++;
            @(negedge clk);
        end
        bus.MemAck = 1'b1;
    endtask

    task automatic check_spill(input int cycles, input int exp_cycles, input logic [2:0] exp_cwp);
        chk("spill_busy_cycles", 32'(cycles), 32'(exp_cycles));
        chk("spill_cwp", {29'd0, bus.CWP}, {29'd0, exp_cwp});
        chk("spill_nwrites", 32'(n_wr), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("spill_addr[%0d]", i), wr_addr[i], 32'h0000_F000 + 32'(4 * i));
            chk($sformatf("spill_data[%0d]", i), wr_data[i], 32'h0000_1110 + 32'(i));
        end
    endtask

    task automatic saves6();
        for (int i = 0; i < 6; i++) do_req(1'b1, 1'b0);
    endtask

    initial begin
        int          cyc;
        logic [7:0]  exp_re;

        vt[0] = '{s: 1'b0, r: 1'b1, cwp: 3'd0, err: 1'b1};
        vt[1] = '{s: 1'b1, r: 1'b1, cwp: 3'd0, err: 1'b1};
        for (int i = 0; i < 6; i++) vt[2 + i] = '{s: 1'b1, r: 1'b0, cwp: 3'(7 - i), err: 1'b0};
        for (int i = 0; i < 6; i++) vt[8 + i] = '{s: 1'b0, r: 1'b1, cwp: 3'(2 + i), err: 1'b0};

        bus.Save = 1'b0;
        bus.Restore = 1'b0;
        bus.MemAck = 1'b1;
        bus.MemRdata = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cwp", {29'd0, bus.CWP}, 32'd0);
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_error", {31'd0, bus.Error}, 32'd0);
        chk("rst_re", {24'd0, bus.RE}, 32'h01);
        chk("rst_memreq", {31'd0, bus.MemReq}, 32'd0);
        chk("rst_rfwe", {31'd0, bus.RfWE}, 32'd0);
        chk("rst_rfaddr", {27'd0, bus.RfAddr}, 32'd0);
        chk("rst_memaddr", bus.MemAddr, 32'd0);

        // Illegal requests, then six non-trapping saves.
        for (int i = 0; i < 8; i++) begin
            do_req(vt[i].s, vt[i].r);
            exp_re = 8'b1 << vt[i].cwp;
            chk($sformatf("vec%0d_cwp", i), {29'd0, bus.CWP}, {29'd0, vt[i].cwp});
            chk($sformatf("vec%0d_err", i), {31'd0, bus.Error}, {31'd0, vt[i].err});
            chk($sformatf("vec%0d_busy", i), {31'd0, bus.Busy}, 32'd0);
            chk($sformatf("vec%0d_re", i), {24'd0, bus.RE}, {24'd0, exp_re});
        end

        // Overflow: spill window 4.
        do_req(1'b1, 1'b0);
        run_op(-1, 0, 200, cyc);
        check_spill(cyc, 32, 3'd1);
        chk("spill_err", {31'd0, bus.Error}, 32'd0);

        for (int i = 8; i < 14; i++) begin
            do_req(vt[i].s, vt[i].r);
            exp_re = 8'b1 << vt[i].cwp;
            chk($sformatf("vec%0d_cwp", i), {29'd0, bus.CWP}, {29'd0, vt[i].cwp});
            chk($sformatf("vec%0d_err", i), {31'd0, bus.Error}, {31'd0, vt[i].err});
            chk($sformatf("vec%0d_re", i), {24'd0, bus.RE}, {24'd0, exp_re});
        end

        // Underflow: fill window 0 from the frame just spilled.
        do_req(1'b0, 1'b1);
        run_op(-1, 0, 200, cyc);
        chk("fill_busy_cycles", 32'(cyc), 32'd32);
        chk("fill_cwp", {29'd0, bus.CWP}, 32'd0);
        chk("fill_nwe", 32'(n_we), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fill_re[%0d]", i), {24'd0, we_re[i]}, 32'h01);
            chk($sformatf("fill_rfaddr[%0d]", i), {27'd0, we_addr[i]}, 32'(16 + i));
            chk($sformatf("fill_data[%0d]", i), we_data[i], 32'h0000_1110 + 32'(i));
        end

        // Depth back to zero: the next restore traps as an error.
        do_req(1'b0, 1'b1);
        chk("empty_restore_err", {31'd0, bus.Error}, 32'd1);
        chk("empty_restore_cwp", {29'd0, bus.CWP}, 32'd0);
        @(negedge clk);
        chk("error_one_cycle", {31'd0, bus.Error}, 32'd0);

        // Spill with MemAck withheld for 3 cycles on word 5.
        saves6();
        chk("pre_stall_cwp", {29'd0, bus.CWP}, 32'd2);
        do_req(1'b1, 1'b0);
        run_op(5, 3, 200, cyc);
        check_spill(cyc, 35, 3'd1);

        // Reset in the middle of a spill.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        saves6();
        do_req(1'b1, 1'b0);
        run_op(-1, 0, 10, cyc);
        chk("abort_busy_before", {31'd0, bus.Busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_memreq", {31'd0, bus.MemReq}, 32'd0);
        chk("abort_busy", {31'd0, bus.Busy}, 32'd0);
        chk("abort_re", {24'd0, bus.RE}, 32'h01);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_cwp", {29'd0, bus.CWP}, 32'd0);
        do_req(1'b0, 1'b1);
        chk("abort_depth_err", {31'd0, bus.Error}, 32'd1);
        saves6();
        do_req(1'b1, 1'b0);
        run_op(-1, 0, 200, cyc);
        check_spill(cyc, 32, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
